// File: rtl/write_order_scheduler.sv
// write_order_scheduler: per-slave AXI write scheduler. Round-robin AW grant
// that holds until the AW handshake, plus an in-order FIFO of granted master
// indices that steers the W channel until each WLAST beat.
// Optional build macro XBAR_SCHED_STATS_EN adds saturating per-master AW
// handshake counters on port grant_count.
module write_order_scheduler #(
  parameter int unsigned MASTERS           = 2,
  parameter int unsigned SLAVES            = 2,
  parameter int unsigned I_AM_SLAVE_NUMBER = 0,
  parameter int unsigned DEPTH             = 4
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETn,
  input  logic [MASTERS-1:0]                   m_awvalid,
  input  logic [MASTERS*$clog2(SLAVES)-1:0]    m_awdest,
  input  logic                                 s_awready,
  output logic [$clog2(MASTERS)-1:0]           aw_sel,
  output logic                                 aw_sel_valid,
  output logic [MASTERS-1:0]                   m_awready,
  input  logic [MASTERS-1:0]                   m_wvalid,
  input  logic [MASTERS-1:0]                   m_wlast,
  input  logic                                 s_wready,
  output logic [$clog2(MASTERS)-1:0]           w_sel,
  output logic                                 w_sel_valid,
  output logic [MASTERS-1:0]                   m_wready,
  output logic [$clog2(DEPTH+1)-1:0]           outstanding
`ifdef XBAR_SCHED_STATS_EN
  ,
  output logic [MASTERS*16-1:0]                grant_count
`endif
);

  localparam int unsigned MW   = $clog2(MASTERS);
  localparam int unsigned SW   = $clog2(SLAVES);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned PTRW = PW + 1;
  localparam int unsigned OW   = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [MW-1:0]     aw_sel_q, aw_sel_d;
  logic [MW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [MW-1:0]     fifo_mem [DEPTH];

  logic [MASTERS-1:0] req;
  logic [MW-1:0]      rr_cand;
  logic [MW-1:0]      rr_winner;
  logic               rr_found;
  logic               fifo_full;
  logic               fifo_empty;
  logic               aw_push;
  logic               w_pop;
  logic [MW-1:0]      w_head;

  // Requests aimed at this slave
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      req[i] = m_awvalid[i] && (m_awdest[i*SW +: SW] == SW'(I_AM_SLAVE_NUMBER));
    end
  end

  // Round-robin pick: first request scanning upward from rr_ptr
  always_comb begin
    rr_cand   = '0;
    rr_winner = '0;
    rr_found  = 1'b0;
    for (int unsigned k = 0; k < MASTERS; k++) begin
      rr_cand = MW'((32'(rr_ptr_q) + k) % MASTERS);
      if (!rr_found && req[rr_cand]) begin
        rr_found  = 1'b1;
        rr_winner = rr_cand;
      end
    end
  end

  // FIFO status and channel handshakes
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    w_head     = fifo_mem[rd_ptr_q[PW-1:0]];
    aw_push    = (state_q == LOCKED) && m_awvalid[aw_sel_q] && s_awready;
    w_pop      = !fifo_empty && s_wready && m_wvalid[w_head] && m_wlast[w_head];
  end

  // AW grant FSM next state; grant is held until the AW handshake
  always_comb begin
    state_d  = state_q;
    aw_sel_d = aw_sel_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (rr_found && !fifo_full) begin
          aw_sel_d = rr_winner;
          state_d  = LOCKED;
        end
      end
      LOCKED: begin
        if (aw_push) begin
          state_d  = IDLE;
          rr_ptr_d = (aw_sel_q == MW'(MASTERS - 1)) ? '0 : aw_sel_q + MW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Order FIFO pointer update
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTRW'(aw_push);
    rd_ptr_d = rd_ptr_q + PTRW'(w_pop);
  end

  // State, grant and pointer registers
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q  <= IDLE;
      aw_sel_q <= '0;
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      aw_sel_q <= aw_sel_d;
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Order FIFO storage; contents are discarded on reset via the pointers
  always_ff @(posedge ACLK) begin
    if (aw_push) begin
      fifo_mem[wr_ptr_q[PW-1:0]] <= aw_sel_q;
    end
  end

  // Mux selects and per-master readies
  always_comb begin
    aw_sel       = aw_sel_q;
    aw_sel_valid = (state_q == LOCKED);
    m_awready    = '0;
    if (state_q == LOCKED) begin
      m_awready[aw_sel_q] = s_awready;
    end
    w_sel_valid = !fifo_empty;
    w_sel       = fifo_empty ? '0 : w_head;
    m_wready    = '0;
    if (!fifo_empty) begin
      m_wready[w_head] = s_wready;
    end
    outstanding = OW'(wr_ptr_q - rd_ptr_q);
  end

`ifdef XBAR_SCHED_STATS_EN
  logic [15:0] grant_count_q [MASTERS];
  logic [15:0] grant_count_d [MASTERS];

  // Saturating AW handshake count per master
  always_comb begin
    for (int unsigned i = 0; i < MASTERS; i++) begin
      grant_count_d[i] = grant_count_q[i];
      if (aw_push && (aw_sel_q == MW'(i)) && (grant_count_q[i] != 16'hFFFF)) begin
        grant_count_d[i] = grant_count_q[i] + 16'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge ACLK) begin
    for (int unsigned i = 0; i < MASTERS; i++) begin
      if (!ARESETn) begin
        grant_count_q[i] <= '0;
      end else begin
        grant_count_q[i] <= grant_count_d[i];
      end
    end
  end

  // Flatten counters onto the output bus
  always_comb begin
    grant_count = '0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      grant_count[i*16 +: 16] = grant_count_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_write_order_scheduler.sv
// Randomized bench for write_order_scheduler with a queue-based reference
// model and scoreboards for AW grant order and W routing order.
module tb_write_order_scheduler;

  localparam int unsigned M   = 2;
  localparam int unsigned S   = 2;
  localparam int unsigned SLV = 0;
  localparam int unsigned D   = 4;
  localparam int unsigned MW  = $clog2(M);
  localparam int unsigned SW  = $clog2(S);
  localparam int unsigned OW  = $clog2(D + 1);
  localparam int          PHASE_LEN = 800;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic [M-1:0]      m_awvalid = '0;
  logic [M*SW-1:0]   m_awdest = '0;
  logic              s_awready = 1'b0;
  logic [MW-1:0]     aw_sel;
  logic              aw_sel_valid;
  logic [M-1:0]      m_awready;
  logic [M-1:0]      m_wvalid = '0;
  logic [M-1:0]      m_wlast = '0;
  logic              s_wready = 1'b0;
  logic [MW-1:0]     w_sel;
  logic              w_sel_valid;
  logic [M-1:0]      m_wready;
  logic [OW-1:0]     outstanding;
`ifdef XBAR_SCHED_STATS_EN
  logic [M*16-1:0]   grant_count;
`endif

  write_order_scheduler #(
    .MASTERS(M), .SLAVES(S), .I_AM_SLAVE_NUMBER(SLV), .DEPTH(D)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m_awvalid(m_awvalid), .m_awdest(m_awdest), .s_awready(s_awready),
    .aw_sel(aw_sel), .aw_sel_valid(aw_sel_valid), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wlast(m_wlast), .s_wready(s_wready),
    .w_sel(w_sel), .w_sel_valid(w_sel_valid), .m_wready(m_wready),
    .outstanding(outstanding)
`ifdef XBAR_SCHED_STATS_EN
    , .grant_count(grant_count)
`endif
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state (spec-level: grant flag, round-robin pointer, order queue)
  bit mlocked = 1'b0;
  int msel = 0;
  int mrr  = 0;
  int mfifo[$];
  int exp_aw_q[$];
  int exp_w_q[$];
  int mcnt[M];
  int m_win, m_idx;
  bit m_push, m_pop;
  bit saw_full = 1'b0;
  bit saw_pushpop = 1'b0;

  int phase = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  // Reference model: apply the scheduling rules at each clock edge
  always @(posedge ACLK) begin
    if (!ARESETn) begin
      mlocked = 1'b0; msel = 0; mrr = 0;
      mfifo.delete(); exp_aw_q.delete(); exp_w_q.delete();
      for (int i = 0; i < M; i++) mcnt[i] = 0;
    end else begin
      m_push = mlocked && m_awvalid[msel] && s_awready;
      m_pop  = (mfifo.size() > 0) && s_wready && m_wvalid[mfifo[0]] && m_wlast[mfifo[0]];
      if (mfifo.size() == D) saw_full = 1'b1;
      if (m_push && m_pop) saw_pushpop = 1'b1;
      m_win = -1;
      if (!mlocked && mfifo.size() < D) begin
        for (int k = 0; k < M; k++) begin
          m_idx = (mrr + k) % M;
          if (m_win < 0 && m_awvalid[m_idx] && m_awdest[m_idx*SW +: SW] == SW'(SLV)) m_win = m_idx;
        end
      end
      if (m_pop) void'(mfifo.pop_front());
      if (m_push) begin
        mfifo.push_back(msel);
        exp_w_q.push_back(msel);
        if (mcnt[msel] < 16'hFFFF) mcnt[msel]++;
        mrr = (msel + 1) % M;
        mlocked = 1'b0;
      end else if (m_win >= 0) begin
        msel = m_win;
        mlocked = 1'b1;
        exp_aw_q.push_back(m_win);
      end
    end
  end

  bit   prev_asv = 1'b0;
  logic [M-1:0] aw_hs_seen = '0;
  logic [M-1:0] w_hs_seen  = '0;
  int   n_grant[M];
  int   ph2_m1_grants = 0;
  int   sz, exp_v;

  // Monitor: compare DUT outputs mid-cycle, pop scoreboards on grants and WLAST beats
  always @(negedge ACLK) begin
    if (mon_en) begin
      check("aw_sel_valid", 32'(aw_sel_valid), 32'(mlocked));
      if (aw_sel_valid && !prev_asv) begin
        check("grant_pending", 32'(exp_aw_q.size() != 0), 32'd1);
        if (exp_aw_q.size() != 0) begin
          exp_v = exp_aw_q.pop_front();
          check("grant_order", 32'(aw_sel), 32'(exp_v));
          n_grant[aw_sel]++;
          if (phase == 2 && cyc >= 2*PHASE_LEN + 200 && aw_sel == MW'(1)) ph2_m1_grants++;
        end
      end
      if (mlocked) check("aw_sel_hold", 32'(aw_sel), 32'(msel));
      exp_v = (mlocked && s_awready) ? (1 << msel) : 0;
      check("m_awready", 32'(m_awready), 32'(exp_v));
      sz = mfifo.size();
      check("w_sel_valid", 32'(w_sel_valid), 32'(sz > 0));
      exp_v = 0;
      if (sz > 0) exp_v = mfifo[0];
      check("w_sel", 32'(w_sel), 32'(exp_v));
      exp_v = (sz > 0 && s_wready) ? (1 << mfifo[0]) : 0;
      check("m_wready", 32'(m_wready), 32'(exp_v));
      check("outstanding", 32'(outstanding), 32'(sz));
      for (int j = 0; j < M; j++) begin
        if (m_wvalid[j] && m_wready[j] && m_wlast[j]) begin
          check("wlast_pending", 32'(exp_w_q.size() != 0), 32'd1);
          if (exp_w_q.size() != 0) begin
            exp_v = exp_w_q.pop_front();
            check("w_order", 32'(j), 32'(exp_v));
          end
        end
      end
      aw_hs_seen = m_awvalid & m_awready;
      w_hs_seen  = m_wvalid & m_wready;
      prev_asv   = aw_sel_valid;
    end
  end

  // Master-side stimulus state
  bit aw_pend[M];
  int aw_dst[M];
  int aw_len[M];
  int beat[M];
  int wq[M][$];
  bit did_rst3 = 1'b0;
  int p_aw, p_d0, p_saw, p_sw, p_w;
  bit whold;

  initial begin
    for (int i = 0; i < M; i++) begin
      aw_pend[i] = 1'b0; aw_dst[i] = 0; aw_len[i] = 1; beat[i] = 0; n_grant[i] = 0; mcnt[i] = 0;
    end
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    mon_en  = 1'b1;

    for (cyc = 0; cyc < 4*PHASE_LEN; cyc++) begin
      @(posedge ACLK);
      #1;
      phase = cyc / PHASE_LEN;
      case (phase)
        0: begin p_aw = 60; p_d0 = 80;  p_saw = 80; p_sw = 70; p_w = 70; end
        1: begin p_aw = 90; p_d0 = 100; p_saw = 90; p_sw = 10; p_w = 80; end
        2: begin p_aw = 70; p_d0 = 100; p_saw = 70; p_sw = 60; p_w = 70; end
        default: begin p_aw = 50; p_d0 = 50; p_saw = 50; p_sw = 50; p_w = 50; end
      endcase

      if (!ARESETn) begin
        ARESETn = 1'b1;
        for (int i = 0; i < M; i++) begin
          aw_pend[i] = 1'b0; beat[i] = 0; wq[i].delete();
        end
        m_awvalid = '0; m_wvalid = '0; m_wlast = '0;
      end else begin
        for (int i = 0; i < M; i++) begin
          if (aw_hs_seen[i]) begin
            wq[i].push_back(aw_len[i]);
            aw_pend[i] = 1'b0;
          end else if (aw_pend[i] && aw_dst[i] != SLV && $urandom_range(3) == 0) begin
            aw_pend[i] = 1'b0;
          end
          if (w_hs_seen[i] && wq[i].size() > 0) begin
            if (beat[i] == wq[i][0] - 1) begin
              void'(wq[i].pop_front());
              beat[i] = 0;
            end else begin
              beat[i]++;
            end
          end
        end
        if (phase == 1 && !did_rst3 && mlocked && mfifo.size() == 3) begin
          ARESETn = 1'b0;
          did_rst3 = 1'b1;
        end else if (phase == 3 && $urandom_range(299) == 0) begin
          ARESETn = 1'b0;
        end
      end

      for (int i = 0; i < M; i++) begin
        if (!aw_pend[i] && $urandom_range(99) < p_aw) begin
          aw_pend[i] = 1'b1;
          if (phase == 2) aw_dst[i] = (i == 1) ? 1 : 0;
          else aw_dst[i] = ($urandom_range(99) < p_d0) ? 0 : 1;
          aw_len[i] = $urandom_range(4, 1);
        end
        m_awvalid[i] = aw_pend[i];
        m_awdest[i*SW +: SW] = SW'(aw_dst[i]);
        if (wq[i].size() > 0) begin
          whold = m_wvalid[i] && !w_hs_seen[i];
          if (!whold) m_wvalid[i] = ($urandom_range(99) < p_w);
          m_wlast[i] = (beat[i] == wq[i][0] - 1);
        end else begin
          m_wvalid[i] = 1'b0;
          m_wlast[i]  = 1'b0;
        end
      end
      s_awready = ($urandom_range(99) < p_saw);
      s_wready  = ($urandom_range(99) < p_sw);
    end

    @(negedge ACLK);
    check("saw_fifo_full", 32'(saw_full), 32'd1);
    check("saw_push_pop_same_cycle", 32'(saw_pushpop), 32'd1);
    check("mid_txn_reset_hit", 32'(did_rst3), 32'd1);
    check("m0_granted", 32'(n_grant[0] > 0), 32'd1);
    check("m1_granted", 32'(n_grant[1] > 0), 32'd1);
    check("m1_not_granted_when_dest_other", 32'(ph2_m1_grants), 32'd0);
`ifdef XBAR_SCHED_STATS_EN
    for (int i = 0; i < M; i++) check("grant_count", 32'(grant_count[i*16 +: 16]), 32'(mcnt[i]));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/write_order_scheduler.md
Name: write_order_scheduler

Overview:
Per-slave AXI write-path scheduler for the crossbar. It grants one master's AW request to this slave using round-robin priority and locks that grant until the AW handshake. It records each granted master index in an in-order FIFO and steers the W channel from the FIFO head until the WLAST beat. AW can therefore run up to DEPTH transactions ahead of W, while W data stays in AW order.

Parameters:
MASTERS, 2, number of masters (>=2); MW = $clog2(MASTERS)
SLAVES, 2, number of slaves (>=2); SW = $clog2(SLAVES)
I_AM_SLAVE_NUMBER, 0, slave index served by this instance
DEPTH, 4, outstanding-AW order FIFO entries (power of 2, >=2)

Ports:
ACLK  input  1  clock
ARESETn  input  1  synchronous active-low reset
m_awvalid  input  MASTERS  per-master AW valid
m_awdest  input  MASTERS*SW  per-master decoded slave number; master i occupies bits [i*SW +: SW]
s_awready  input  1  slave AW ready
aw_sel  output  MW  master index driving the AW mux
aw_sel_valid  output  1  AW grant locked
m_awready  output  MASTERS  per-master AW ready
m_wvalid  input  MASTERS  per-master W valid
m_wlast  input  MASTERS  per-master WLAST
s_wready  input  1  slave W ready
w_sel  output  MW  master index driving the W mux
w_sel_valid  output  1  W routing active (FIFO non-empty)
m_wready  output  MASTERS  per-master W ready
outstanding  output  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset: ARESETn is synchronous, active-low, clock ACLK. State IDLE, rr_ptr=0, FIFO empty, outstanding=0, aw_sel=0, aw_sel_valid=0, w_sel=0, w_sel_valid=0, m_awready=0, m_wready=0. Reset mid-transaction discards all grants and FIFO contents.
- req[i] = m_awvalid[i] & (m_awdest[i] == I_AM_SLAVE_NUMBER).
- AW FSM, two states:
  - IDLE: if |req and FIFO not full, register winner into aw_sel and go to LOCKED. Winner is the first set req found scanning rr_ptr, rr_ptr+1, ... mod MASTERS. Otherwise stay in IDLE.
  - LOCKED: aw_sel_valid=1 and m_awready[aw_sel]=s_awready; all other m_awready bits are 0. On handshake (m_awvalid[aw_sel] & s_awready): push aw_sel, set rr_ptr=(aw_sel+1) mod MASTERS (wraps MASTERS-1 to 0), go to IDLE.
  - Grant latency is 1 cycle from req to aw_sel_valid. There is a 1-cycle bubble between consecutive grants.
  - The grant never changes while LOCKED; the AXI valid-stability rule guarantees req stays high.
- W steering:
  - w_sel = FIFO head; w_sel_valid = !empty.
  - m_wready[w_sel] = w_sel_valid & s_wready; all other bits 0.
  - Beat handshake = m_wvalid[w_sel] & m_wready[w_sel]. Pop on a handshake with m_wlast[w_sel]=1.
  - New head is visible the next cycle.
- FIFO:
  - Grant is blocked while full; no push can occur when full.
  - Simultaneous push and pop leaves outstanding unchanged.
  - Pop when empty is impossible since m_wready is 0.
  - Pointers are $clog2(DEPTH)+1 bits with wrap bit; outstanding = wr_ptr - rd_ptr.
- W of an AW not yet handshaken is never accepted. W before AW is not supported.

Optional Feature:
Macro XBAR_SCHED_STATS_EN.
- Defined: adds output grant_count [MASTERS*16-1:0], one 16-bit counter per master. The counter increments on each AW handshake for that master, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then m_awvalid=2'b01 with dest0=0 (I_AM_SLAVE_NUMBER=0) and s_awready=1 -> aw_sel_valid high at cycle 1 with aw_sel=0; m_awready=2'b01; outstanding=1 next cycle; w_sel=0, w_sel_valid=1.
- Both masters request continuously, s_awready=1, DEPTH=4, W held off -> grants alternate 0,1,0,1; a 5th grant is blocked with outstanding=4 and aw_sel_valid=0 until a WLAST pop.
- FIFO holds [1,0]; master1 sends 3 beats with last on beat 3 while m_wvalid[0]=1 -> m_wready[0]=0 throughout; after beat 3, w_sel=0 and outstanding=1.
- A push (AW handshake) and a pop (WLAST beat) in the same cycle with outstanding=2 -> outstanding stays 2 and order is preserved.
- m_awdest[1]=1 for master1 only -> master1 is never granted; aw_sel_valid toggles only for master0.
- ARESETn low while LOCKED with outstanding=3 -> next cycle all outputs are 0, FIFO is empty, and rr_ptr=0; with XBAR_SCHED_STATS_EN, counters read 0.
